hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the 5-stage MIPS core. Decides each cycle whether the PC and pipeline registers advance, stall or are flushed. Covers load-use hazards and taken-branch flushes detected in ID, plus multi-cycle data-memory accesses signalled by a req/ack handshake. Sits beside the forwarding unit and drives the write-enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

## Interface
- MAX_WAIT, 15: memory-wait cycles tolerated before timeout (1..255).
- CNT_W, 16: stall-counter width.

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- IdExMemRead  input  1  instruction in ID/EX is a load.
- IdExRt  input  5  load destination register in ID/EX.
- IfIdRs  input  5  source register rs of the instruction in ID.
- IfIdRt  input  5  source register rt of the instruction in ID.
- branchTaken  input  1  ID-stage branch/jump resolved taken.
- memReq  input  1  instruction in EX/MEM accesses data memory.
- memAck  input  1  data memory completes the access this cycle.
- pcWrite  output  1  PC load enable.
- ifIdWrite  output  1  IF/ID load enable.
- pipeWrite  output  1  load enable for ID/EX, EX/MEM and MEM/WB.
- ifIdFlush  output  1  IF/ID loads a NOP.
- idExFlush  output  1  ID/EX loads a bubble (control zeroed).
- memWbFlush  output  1  MEM/WB loads a bubble.
- memError  output  1  sticky memory-timeout flag.
- stallCount  output  CNT_W  saturating count of cycles with pcWrite=0.

## Operation
- States: RUN, MEM_WAIT, HALT. Outputs are Mealy (state plus current inputs).
- loadUse = IdExMemRead & (IdExRt != 0) & (IdExRt == IfIdRs | IdExRt == IfIdRt).
- memStall = memReq & ~memAck.
- Default outputs are pcWrite=ifIdWrite=pipeWrite=1 and all flushes 0.
- Priority in RUN is memStall > loadUse > branchTaken.
  - memStall: pcWrite=ifIdWrite=pipeWrite=0, memWbFlush=1. Next state is MEM_WAIT. Wait counter is cleared to 1.
  - loadUse: pcWrite=ifIdWrite=0, idExFlush=1, pipeWrite=1. branchTaken is ignored because its operands are stale.
  - branchTaken: ifIdFlush=1, everything else advances.
- MEM_WAIT:
  - If memAck=0: freeze as above and increment the wait counter. When the counter equals MAX_WAIT, go to HALT and set memError.
  - If memAck=1: the pipeline advances this cycle and the state returns to RUN. In that same cycle, loadUse and branchTaken are evaluated exactly as in RUN, except that memStall is ignored.
- HALT: pcWrite=ifIdWrite=pipeWrite=0, memWbFlush=1. Left only by reset.
- stallCount increments on every cycle with pcWrite=0 and holds at all-ones. It never wraps.
- Register 0 never triggers loadUse.

## Timing
- Reset (rst_n low, asynchronous): state=RUN, wait counter=0, stallCount=0, memError=0.
- While rst_n is low, pcWrite=ifIdWrite=pipeWrite=0 and all flushes are 0.
- A mid-access reset abandons MEM_WAIT/HALT immediately. The first cycle after release is RUN.
- Load-use costs exactly 1 stall cycle. On the next edge the load has moved to EX/MEM, so loadUse clears without any state being held.
- Memory access with ack latency N ≥ 1 cycles after first memReq costs N freeze cycles. memAck in the first cycle costs 0.
- Timeout: HALT is entered on the edge after the MAX_WAIT-th consecutive unacked cycle. memError rises at that edge.
- memAck while in RUN with memReq=0 is ignored.
- Simultaneous loadUse and branchTaken gives the stall only. The branch is re-resolved next cycle.

## Test plan
- Reset/idle: hold rst_n=0 for 3 cycles, then release with no hazards.
  - Required: all enables 0 during reset, then 1/1/1.
  - Required: flushes 0, stallCount=0, memError=0.
- Load-use: IdExMemRead=1, IdExRt=8, IfIdRs=8 for one cycle.
  - Required: pcWrite=0, ifIdWrite=0, idExFlush=1 for exactly 1 cycle, then stallCount=1.
  - Repeat with IdExRt=0: no stall.
- Branch conflict: branchTaken=1 alone.
  - Required: ifIdFlush=1 for 1 cycle.
  - With loadUse in the same cycle: ifIdFlush=0 and a stall occurs instead.
- Memory wait: memReq=1 held, memAck raised on the 4th cycle.
  - Required: 3 freeze cycles with memWbFlush=1, advance on the ack cycle.
  - Required: back in RUN, stallCount=3.
- Timeout: MAX_WAIT=15, memReq=1, memAck=0 forever.
  - Required: memError=1 after 15 cycles, freeze persists.
  - Required: asserting rst_n=0 mid-HALT clears memError and stallCount immediately.
- Saturation: CNT_W=4, force 20 stall cycles.
  - Required: stallCount=15 and holds; it does not wrap to 4.

Source files
------------

// File: rtl/hazard_controller_if.sv
// Hazard-controller bundle: ID/EX hazard inputs and memory handshake in, pipeline enables/flushes out.
// master: pipeline side (drives hazard inputs, receives enables); slave: controller side.
// Ports: IdExMemRead/IdExRt/IfIdRs/IfIdRt/branchTaken/memReq/memAck -> pcWrite/ifIdWrite/pipeWrite/flushes/memError/stallCount.
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic             IdExMemRead;
  logic [4:0]       IdExRt;
  logic [4:0]       IfIdRs;
  logic [4:0]       IfIdRt;
  logic             branchTaken;
  logic             memReq;
  logic             memAck;
  logic             pcWrite;
  logic             ifIdWrite;
  logic             pipeWrite;
  logic             ifIdFlush;
  logic             idExFlush;
  logic             memWbFlush;
  logic             memError;
  logic [CNT_W-1:0] stallCount;

  modport master (
    output IdExMemRead, IdExRt, IfIdRs, IfIdRt, branchTaken, memReq, memAck,
    input  pcWrite, ifIdWrite, pipeWrite, ifIdFlush, idExFlush, memWbFlush,
           memError, stallCount
  );

  modport slave (
    input  IdExMemRead, IdExRt, IfIdRs, IfIdRt, branchTaken, memReq, memAck,
    output pcWrite, ifIdWrite, pipeWrite, ifIdFlush, idExFlush, memWbFlush,
           memError, stallCount
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencing: stall on load-use, flush IF/ID on taken branch, freeze on data-memory wait.
// Latency: enables/flushes are Mealy (same cycle); memError/stallCount update on the next edge.
// Backpressure: memReq without memAck freezes the whole pipe; MAX_WAIT unacked cycles latch HALT until reset.
// Ports: clk, rst_n (async active-low), hz (slave modport of hazard_controller_if).
module hazard_controller #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_use, mem_stall, eval_hz;
  logic pc_we, ifid_we, pipe_we, ifid_fl, idex_fl, mwb_fl;

  always_comb begin
    // A load into $0 never produces a value anyone can depend on.
    load_use  = hz.IdExMemRead & (hz.IdExRt != 5'd0) &
                ((hz.IdExRt == hz.IfIdRs) | (hz.IdExRt == hz.IfIdRt));
    mem_stall = hz.memReq & ~hz.memAck;

    pc_we   = 1'b1;
    ifid_we = 1'b1;
    pipe_we = 1'b1;
    ifid_fl = 1'b0;
    idex_fl = 1'b0;
    mwb_fl  = 1'b0;
    eval_hz = 1'b0;
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          pipe_we = 1'b0;
          mwb_fl  = 1'b1;
          // This cycle is already the first unacked one.
          wait_d  = 8'd1;
          if (MAX_WAIT_C == 8'd1) begin
            state_d = HALT;
            err_d   = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end else begin
          eval_hz = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!hz.memAck) begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          pipe_we = 1'b0;
          mwb_fl  = 1'b1;
          wait_d  = wait_q + 8'd1;
          if (wait_q + 8'd1 == MAX_WAIT_C) begin
            state_d = HALT;
            err_d   = 1'b1;
          end
        end else begin
          // Ack cycle: pipe advances, so ID-stage hazards apply as in RUN.
          state_d = RUN;
          eval_hz = 1'b1;
        end
      end
      HALT: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        pipe_we = 1'b0;
        mwb_fl  = 1'b1;
      end
      default: state_d = RUN;
    endcase

    // Load-use wins over branch: branch operands are stale until the load lands.
    if (eval_hz) begin
      if (load_use) begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        idex_fl = 1'b1;
      end else if (hz.branchTaken) begin
        ifid_fl = 1'b1;
      end
    end

    cnt_d = cnt_q;
    if (!pc_we && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Enables are forced low while reset is held so no register loads garbage.
  assign hz.pcWrite    = rst_n & pc_we;
  assign hz.ifIdWrite  = rst_n & ifid_we;
  assign hz.pipeWrite  = rst_n & pipe_we;
  assign hz.ifIdFlush  = rst_n & ifid_fl;
  assign hz.idExFlush  = rst_n & idex_fl;
  assign hz.memWbFlush = rst_n & mwb_fl;
  assign hz.memError   = err_q;
  assign hz.stallCount = cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: stimulus pushes expected outputs, a negedge monitor pops and compares.
// Two instances: CNT_W=16 for functional cases, CNT_W=4 for counter saturation.
// Expected control vector order: {pcWrite, ifIdWrite, pipeWrite, ifIdFlush, idExFlush, memWbFlush}.
module tb_hazard_controller;

  logic clk;
  logic rst_n;

  hazard_controller_if #(.CNT_W(16)) hz1 ();
  hazard_controller_if #(.CNT_W(4))  hz2 ();

  hazard_controller #(.MAX_WAIT(15), .CNT_W(16)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz1)
  );

  hazard_controller #(.MAX_WAIT(15), .CNT_W(4)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] C_RST = 6'b000000;
  localparam logic [5:0] C_RUN = 6'b111000;
  localparam logic [5:0] C_LU  = 6'b001010;
  localparam logic [5:0] C_BR  = 6'b111100;
  localparam logic [5:0] C_FRZ = 6'b000001;

  typedef struct packed {
    logic        sel;
    logic [5:0]  ctl;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    compared = 0;
  int    mismatched = 0;

  // Monitor: the DUT presents a full output vector every cycle; check it mid-cycle.
  exp_t        m_e;
  string       m_nm;
  logic [5:0]  m_ctl;
  logic        m_err;
  logic [15:0] m_cnt;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e  = exp_q.pop_front();
      m_nm = name_q.pop_front();
      if (m_e.sel) begin
        m_ctl = {hz2.pcWrite, hz2.ifIdWrite, hz2.pipeWrite,
                 hz2.ifIdFlush, hz2.idExFlush, hz2.memWbFlush};
        m_err = hz2.memError;
        m_cnt = {12'd0, hz2.stallCount};
      end else begin
        m_ctl = {hz1.pcWrite, hz1.ifIdWrite, hz1.pipeWrite,
                 hz1.ifIdFlush, hz1.idExFlush, hz1.memWbFlush};
        m_err = hz1.memError;
        m_cnt = hz1.stallCount;
      end
      compared++;
      if ({m_ctl, m_err, m_cnt} !== {m_e.ctl, m_e.err, m_e.cnt}) begin
        mismatched++;
        $display("FAIL %s: got ctl=%b err=%b cnt=%0d, expected ctl=%b err=%b cnt=%0d",
                 m_nm, m_ctl, m_err, m_cnt, m_e.ctl, m_e.err, m_e.cnt);
      end
    end
  end

  // Drive one cycle of inputs to the selected instance and queue its expected outputs.
  task automatic step(input bit sel, input bit rst,
                      input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                      input logic [4:0] rt, input logic br, input logic req, input logic ack,
                      input logic [5:0] ctl, input logic err, input int cnt, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst;
    if (sel) begin
      hz2.IdExMemRead = mr; hz2.IdExRt = ert; hz2.IfIdRs = rs; hz2.IfIdRt = rt;
      hz2.branchTaken = br; hz2.memReq = req; hz2.memAck = ack;
    end else begin
      hz1.IdExMemRead = mr; hz1.IdExRt = ert; hz1.IfIdRs = rs; hz1.IfIdRt = rt;
      hz1.branchTaken = br; hz1.memReq = req; hz1.memAck = ack;
    end
    e.sel = sel;
    e.ctl = ctl;
    e.err = err;
    e.cnt = 16'(cnt);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle(input bit sel, input logic [5:0] ctl, input logic err,
                      input int cnt, input string nm);
    step(sel, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ctl, err, cnt, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    hz1.IdExMemRead = 0; hz1.IdExRt = 0; hz1.IfIdRs = 0; hz1.IfIdRt = 0;
    hz1.branchTaken = 0; hz1.memReq = 0; hz1.memAck = 0;
    hz2.IdExMemRead = 0; hz2.IdExRt = 0; hz2.IfIdRs = 0; hz2.IfIdRt = 0;
    hz2.branchTaken = 0; hz2.memReq = 0; hz2.memAck = 0;

    // Reset held 3 cycles, then idle.
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0, "reset");
    idle(0, C_RUN, 0, 0, "idle_after_reset");

    // Load-use on rs: one stall cycle, counted on the next edge.
    step(0, 1, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, C_LU, 0, 0, "loaduse_rs");
    idle(0, C_RUN, 0, 1, "loaduse_release");
    // Load into $0 never stalls.
    step(0, 1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_RUN, 0, 1, "loaduse_r0");
    // Load-use on rt.
    step(0, 1, 1, 5'd5, 5'd0, 5'd5, 0, 0, 0, C_LU, 0, 1, "loaduse_rt");
    idle(0, C_RUN, 0, 2, "loaduse_rt_release");

    // Branch alone flushes IF/ID; with load-use, stall only, branch re-resolved next cycle.
    step(0, 1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, C_BR, 0, 2, "branch_alone");
    step(0, 1, 1, 5'd8, 5'd8, 5'd0, 1, 0, 0, C_LU, 0, 2, "branch_with_loaduse");
    step(0, 1, 0, 5'd0, 5'd8, 5'd0, 1, 0, 0, C_BR, 0, 3, "branch_reresolved");

    // Memory wait: ack on the 4th cycle gives 3 freeze cycles.
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 3, "memwait_1");
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 4, "memwait_2");
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 5, "memwait_3");
    step(0, 1, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0, 6, "memwait_ack");
    idle(0, C_RUN, 0, 6, "memwait_back_run");
    // Stray ack in RUN ignored; ack in first request cycle costs nothing.
    step(0, 1, 0, 0, 0, 0, 0, 0, 1, C_RUN, 0, 6, "ack_without_req");
    step(0, 1, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0, 6, "ack_first_cycle");
    // Ack cycle with a load-use pending stalls as in RUN.
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 6, "memwait_then_lu");
    step(0, 1, 1, 5'd8, 5'd8, 0, 0, 1, 1, C_LU, 0, 7, "ack_with_loaduse");
    idle(0, C_RUN, 0, 8, "ack_lu_release");

    // Timeout: 15 unacked cycles, then HALT with memError; freeze persists.
    for (int k = 1; k <= 15; k++)
      step(0, 1, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 8 + k - 1, "timeout_wait");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, C_FRZ, 1, 23, "halt_1");
    step(0, 1, 0, 0, 0, 0, 0, 0, 1, C_FRZ, 1, 24, "halt_2");
    // Reset mid-HALT clears state immediately.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0, "halt_reset");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0, "halt_reset_hold");
    idle(0, C_RUN, 0, 0, "after_halt_reset");

    // Saturation on the 4-bit counter instance: 20 forced stall cycles.
    for (int k = 1; k <= 20; k++)
      step(1, 1, 0, 0, 0, 0, 0, 1, 0, C_FRZ, (k >= 16) ? 1'b1 : 1'b0,
           (k - 1 > 15) ? 15 : k - 1, "saturate");
    idle(1, C_FRZ, 1, 15, "saturate_hold");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
